// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and default sizes for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF  = 4;
    localparam int MEM_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

    // Sequencer states: normal issue, frozen on data memory, dead after timeout.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and control/status outputs of the sequencer.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) ();

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_MemRead;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mem_wb_bubble;
    logic                  halted;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    // Pipeline side: reports hazards, receives enables/flushes.
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, halted, stall_cycles, flush_events
    );

    // Sequencer side.
    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_MemRead, ex_branch_taken, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, halted, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the
// instruction in ID. Register 0 is hardwired, so it never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_MemRead,
    output logic                  load_use
);

    logic rd_nonzero_s;
    logic src_match_s;

    assign rd_nonzero_s = (ex_rd != {REG_ADDR_W{1'b0}});
    assign src_match_s  = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign load_use     = ex_MemRead && rd_nonzero_s && src_match_s;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Control outputs
// are decoded from the state and the current-cycle hazard inputs.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Saturating increment for the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_r;
    state_e            next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic load_use_s;
    logic frozen_s;
    logic branch_act_s;

    logic pc_en_s;
    logic if_id_en_s;
    logic id_ex_en_s;
    logic ex_mem_en_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;
    logic mem_wb_bubble_s;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .ex_rd      (bus.ex_rd),
        .ex_MemRead (bus.ex_MemRead),
        .load_use   (load_use_s)
    );

    // MEM is held while waiting, so mem_req is implied once in MEM_WAIT.
    assign frozen_s = ((state_r == RUN) && bus.mem_req && !bus.mem_ready) ||
                      ((state_r == MEM_WAIT) && !bus.mem_ready);

    assign branch_act_s = !reset && (state_r != HALT) && !frozen_s && bus.ex_branch_taken;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; release beats timeout when mem_ready lands on the last wait cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    next_state_s = MEM_WAIT;
                end else begin
                    next_state_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    next_state_s = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = MEM_WAIT;
                end
            end
            HALT:    next_state_s = HALT;
            default: next_state_s = RUN;
        endcase
    end

    // Segment enable/flush decode in priority order: reset, halt, memory freeze, branch, load-use.
    always_comb begin
        pc_en_s         = 1'b1;
        if_id_en_s      = 1'b1;
        id_ex_en_s      = 1'b1;
        ex_mem_en_s     = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_flush_s   = 1'b0;
        mem_wb_bubble_s = 1'b0;
        if (reset) begin
            pc_en_s         = 1'b0;
            if_id_flush_s   = 1'b1;
            id_ex_flush_s   = 1'b1;
            mem_wb_bubble_s = 1'b1;
        end else if ((state_r == HALT) || frozen_s) begin
            pc_en_s         = 1'b0;
            if_id_en_s      = 1'b0;
            id_ex_en_s      = 1'b0;
            ex_mem_en_s     = 1'b0;
            mem_wb_bubble_s = 1'b1;
        end else if (bus.ex_branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
            pc_en_s       = 1'b0;
            if_id_en_s    = 1'b0;
            id_ex_flush_s = 1'b1;
        end else begin
            pc_en_s = 1'b1;
        end
    end

    // Wait counter: zero while running, counts unanswered MEM_WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r == RUN) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == MEM_WAIT) && !bus.mem_ready) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Stall counter: every non-reset cycle with the PC held, halt included.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_en_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush counter: taken branches that were actually acted on.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (branch_act_s) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign bus.pc_en         = pc_en_s;
    assign bus.if_id_en      = if_id_en_s;
    assign bus.id_ex_en      = id_ex_en_s;
    assign bus.ex_mem_en     = ex_mem_en_s;
    assign bus.if_id_flush   = if_id_flush_s;
    assign bus.id_ex_flush   = id_ex_flush_s;
    assign bus.mem_wb_bubble = mem_wb_bubble_s;
    assign bus.halted        = (state_r == HALT);
    assign bus.stall_cycles  = stall_cnt_r;
    assign bus.flush_events  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed table, hand-written
// timeout sequences, randomized run against a behavioural model, saturation.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 15;

    // Control vector order: pc, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bubble
    localparam logic [6:0] C_DEF = 7'b1111000;
    localparam logic [6:0] C_RST = 7'b0111111;
    localparam logic [6:0] C_FRZ = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0011010;

    typedef struct {
        logic       rst;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [6:0] ctrl;
        logic       halted;
        int         stall;
        int         flush;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Behavioural model state
    bit m_halt, m_wait;
    int m_waited, m_stall, m_flush;

    vec_t tbl [16];

    pipeline_hazard_ctrl_if intf ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] rs1, input logic [3:0] rs2,
                                input logic [3:0] rd, input logic mr, input logic br,
                                input logic req, input logic rdy, input logic [6:0] ctrl,
                                input logic halted, input int stall, input int flush);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.br = br;
        v.req = req; v.rdy = rdy; v.ctrl = ctrl; v.halted = halted;
        v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic mr, input logic br,
                         input logic req, input logic rdy);
        reset                = rst;
        intf.id_rs1          = rs1;
        intf.id_rs2          = rs2;
        intf.ex_rd           = rd;
        intf.ex_MemRead      = mr;
        intf.ex_branch_taken = br;
        intf.mem_req         = req;
        intf.mem_ready       = rdy;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {intf.pc_en, intf.if_id_en, intf.id_ex_en, intf.ex_mem_en,
                intf.if_id_flush, intf.id_ex_flush, intf.mem_wb_bubble};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Stimulus and checking sequence.
    initial begin
        logic       r_rst, r_mr, r_br, r_req, r_rdy;
        logic [3:0] r_rs1, r_rs2, r_rd;
        logic [6:0] e_ctrl;
        bit         lu;

        //                 rst  rs1  rs2  rd  mr   br   req  rdy  ctrl  halt stall flush
        tbl[0]  = mk(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 1'b0, 0, 0);
        tbl[1]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 0, 0);
        tbl[2]  = mk(1'b0, 4'd5, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 0, 0);
        tbl[3]  = mk(1'b0, 4'd5, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 1, 0);
        tbl[4]  = mk(1'b0, 4'd5, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,  1'b0, 1, 0);
        tbl[5]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 1, 1);
        tbl[6]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 1, 1);
        tbl[7]  = mk(1'b0, 4'd7, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 1, 1);
        tbl[8]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 1, 1);
        tbl[9]  = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 2, 1);
        tbl[10] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 3, 1);
        tbl[11] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 4, 1);
        tbl[12] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,  1'b0, 5, 1);
        tbl[13] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 5, 2);
        tbl[14] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_DEF, 1'b0, 5, 2);
        tbl[15] = mk(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 5, 2);

        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) next_cycle();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr, tbl[i].br,
                  tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d_halted", i), 32'(intf.halted), 32'(tbl[i].halted));
            chk($sformatf("tbl%0d_stall", i), 32'(intf.stall_cycles), tbl[i].stall);
            chk($sformatf("tbl%0d_flush", i), 32'(intf.flush_events), tbl[i].flush);
            next_cycle();
        end

        // Timeout: one RUN freeze cycle plus TIMEOUT wait cycles, then halt.
        for (int i = 0; i <= TIMEOUT; i++) begin
            drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("to_wait%0d_ctrl", i), 32'(ctrl_now()), 32'(C_FRZ));
            chk($sformatf("to_wait%0d_halted", i), 32'(intf.halted), 32'd0);
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("halt%0d_ctrl", i), 32'(ctrl_now()), 32'(C_FRZ));
            chk($sformatf("halt%0d_halted", i), 32'(intf.halted), 32'd1);
            next_cycle();
        end
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("halt_rst_ctrl", 32'(ctrl_now()), 32'(C_RST));
        chk("halt_stall", 32'(intf.stall_cycles), 32'd25);
        next_cycle();
        idle();
        @(negedge clk);
        chk("post_rst_ctrl", 32'(ctrl_now()), 32'(C_DEF));
        chk("post_rst_halted", 32'(intf.halted), 32'd0);
        chk("post_rst_stall", 32'(intf.stall_cycles), 32'd0);
        chk("post_rst_flush", 32'(intf.flush_events), 32'd0);
        next_cycle();

        // Ready on the exact timeout cycle: release wins.
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            next_cycle();
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("edge_release_ctrl", 32'(ctrl_now()), 32'(C_DEF));
        chk("edge_release_halted", 32'(intf.halted), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("edge_after_ctrl", 32'(ctrl_now()), 32'(C_DEF));
        chk("edge_after_halted", 32'(intf.halted), 32'd0);
        chk("edge_after_stall", 32'(intf.stall_cycles), 32'd15);
        next_cycle();

        // Randomized run against the behavioural model.
        m_halt = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 149) == 0);
            r_rs1 = 4'($urandom_range(0, 3));
            r_rs2 = 4'($urandom_range(0, 3));
            r_rd  = 4'($urandom_range(0, 3));
            r_mr  = ($urandom_range(0, 2) == 0);
            r_br  = ($urandom_range(0, 4) == 0);
            r_req = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
            r_rdy = ($urandom_range(0, 5) == 0);
            drive(r_rst, r_rs1, r_rs2, r_rd, r_mr, r_br, r_req, r_rdy);

            lu = r_mr && (r_rd != 4'd0) && ((r_rd == r_rs1) || (r_rd == r_rs2));
            if (r_rst)                              e_ctrl = C_RST;
            else if (m_halt)                        e_ctrl = C_FRZ;
            else if ((m_wait || r_req) && !r_rdy)   e_ctrl = C_FRZ;
            else if (r_br)                          e_ctrl = C_BR;
            else if (lu)                            e_ctrl = C_LU;
            else                                    e_ctrl = C_DEF;

            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("rnd%0d_ctrl", i), 32'(ctrl_now()), 32'(e_ctrl));
                chk($sformatf("rnd%0d_halted", i), 32'(intf.halted), 32'(m_halt));
                chk($sformatf("rnd%0d_stall", i), 32'(intf.stall_cycles), m_stall);
                chk($sformatf("rnd%0d_flush", i), 32'(intf.flush_events), m_flush);
            end
            next_cycle();

            if (r_rst) begin
                m_halt = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
            end else begin
                if (!e_ctrl[6]) m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
                if (e_ctrl == C_BR) m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
                if (!m_halt) begin
                    if (m_wait) begin
                        if (r_rdy) begin
                            m_wait = 0;
                        end else begin
                            m_waited++;
                            if (m_waited == TIMEOUT) begin
                                m_halt = 1;
                                m_wait = 0;
                            end
                        end
                    end else if (r_req && !r_rdy) begin
                        m_wait   = 1;
                        m_waited = 0;
                    end
                end
            end
        end

        // Saturation: sit in halt long enough to overflow a 16-bit counter.
        drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (65600) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("sat%0d_stall", i), 32'(intf.stall_cycles), 32'hFFFF);
            chk($sformatf("sat%0d_halted", i), 32'(intf.halted), 32'd1);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
